// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - shares one single-port synchronous RAM between fetch (IF) and data (DM) ports
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   if_req/if_addr                fetch read request (held until granted)
//   if_gnt/if_rvalid/if_rdata     fetch grant and response (response one cycle after grant)
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata   data request (held until granted)
//   dm_gnt/dm_rvalid/dm_rdata/dm_err      data grant, response and out-of-range flag
//   stall_if/stall_mem            request present but not granted this cycle
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   single-port RAM interface
//   perf_conflict/perf_if_stall   performance counters, present only when ARB_PERF_CNT_EN is defined
//
// Optional feature macro: ARB_PERF_CNT_EN

module riscv_mem_arbiter #(
  parameter int AW         = 10,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [3:0]    dm_be,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [31:0]   dm_rdata,
  output logic          dm_err,
  output logic          stall_if,
  output logic          stall_mem,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]   perf_conflict,
  output logic [31:0]   perf_if_stall,
`endif
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [1:0] RESP_IDLE = 2'd0;
  localparam logic [1:0] RESP_IF   = 2'd1;
  localparam logic [1:0] RESP_DM   = 2'd2;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  logic [1:0] resp_own;
  logic [3:0] starve_cnt;
  logic       starved;
  logic       dm_in_range;
  logic       live;

  // Fetch addresses are never range-checked; only the word index is used.
  logic unused_if_bits;
  assign unused_if_bits = ^{if_addr[31:AW+2], if_addr[1:0]};

  assign live        = ~rst;
  assign starved     = (starve_cnt == 4'(STARVE_MAX));
  assign dm_in_range = (dm_addr[31:AW+2] == '0) && (dm_addr[1:0] == 2'b00);

  // DM normally wins a conflict; IF wins once it has been denied STARVE_MAX times in a row.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (live) begin
      if (if_req && (!dm_req || starved)) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end
    end
  end

  assign stall_if  = live & if_req & ~if_gnt;
  assign stall_mem = live & dm_req & ~dm_gnt;

  // An out-of-range DM access is still granted but never reaches the RAM.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[AW+1:2];
    end else if (dm_gnt && dm_in_range) begin
      mem_en   = 1'b1;
      mem_addr = dm_addr[AW+1:2];
      if (dm_we) begin
        mem_we    = dm_be;
        mem_wdata = dm_wdata;
      end
    end
  end

  // Responses are gated with reset so a read granted just before reset never surfaces.
  always_comb begin
    if_rvalid = live && (resp_own == RESP_IF);
    if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    dm_rvalid = live && ((resp_own == RESP_DM) || (resp_own == RESP_ERR));
    dm_rdata  = (live && (resp_own == RESP_DM)) ? mem_rdata : 32'h0;
    dm_err    = (live && (resp_own == RESP_ERR)) || (dm_gnt && dm_we && !dm_in_range);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_own   <= RESP_IDLE;
      starve_cnt <= 4'd0;
    end else begin
      if (if_gnt) begin
        resp_own <= RESP_IF;
      end else if (dm_gnt && !dm_we) begin
        resp_own <= dm_in_range ? RESP_DM : RESP_ERR;
      end else begin
        resp_own <= RESP_IDLE;
      end

      if (if_req && !if_gnt) begin
        starve_cnt <= (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
      end else begin
        starve_cnt <= 4'd0;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict <= 32'h0;
      perf_if_stall <= 32'h0;
    end else begin
      if (if_req && dm_req) perf_conflict <= perf_conflict + 32'd1;
      if (stall_if)         perf_if_stall <= perf_if_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - self-checking bench for riscv_mem_arbiter against a behavioural model

module tb_riscv_mem_arbiter;

  localparam int AW         = 10;
  localparam int STARVE_MAX = 3;
  localparam int DEPTH      = 1 << AW;

  localparam int PEND_NONE = 0;
  localparam int PEND_IF   = 1;
  localparam int PEND_DM   = 2;
  localparam int PEND_ERR  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          dm_req, dm_we;
  logic [3:0]    dm_be;
  logic [31:0]   dm_addr, dm_wdata;
  logic          dm_gnt, dm_rvalid, dm_err;
  logic [31:0]   dm_rdata;
  logic          stall_if, stall_mem;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   perf_conflict, perf_if_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .stall_if(stall_if), .stall_mem(stall_mem),
`ifdef ARB_PERF_CNT_EN
    .perf_conflict(perf_conflict), .perf_if_stall(perf_if_stall),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // The RAM device the arbiter drives: read-first, one-cycle read latency.
  logic [31:0] ram [0:DEPTH-1] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory contents, length of the current run of denied IF cycles,
  // and the response owed for the access granted last cycle.
  logic [31:0] model_mem [0:DEPTH-1] = '{default: 32'h0};
  int          denied_run = 0;
  int          pend       = PEND_NONE;
  logic [31:0] pend_data  = 32'h0;
  logic        last_if_gnt = 1'b0;
  logic        last_dm_gnt = 1'b0;

  always @(negedge clk) begin
    logic        e_ig, e_dg, oor, e_en, e_err, e_iv, e_dv;
    logic [3:0]  e_we;
    logic [31:0] e_maddr, e_idata, e_ddata;
    int          iw, dw;
    iw   = int'(if_addr[AW+1:2]);
    dw   = int'(dm_addr[AW+1:2]);
    oor  = (dm_addr[31:AW+2] != 0) || (dm_addr[1:0] != 0);
    e_ig = !rst && if_req && (!dm_req || denied_run == STARVE_MAX);
    e_dg = !rst && dm_req && !e_ig;
    e_en = e_ig || (e_dg && !oor);
    e_we = (e_dg && dm_we && !oor) ? dm_be : 4'h0;
    e_maddr = e_ig ? 32'(iw) : 32'(dw);
    e_iv = !rst && pend == PEND_IF;
    e_dv = !rst && (pend == PEND_DM || pend == PEND_ERR);
    e_idata = e_iv ? pend_data : 32'h0;
    e_ddata = (!rst && pend == PEND_DM) ? pend_data : 32'h0;
    e_err = (!rst && pend == PEND_ERR) || (e_dg && dm_we && oor);

    chk("if_gnt", 32'(if_gnt), 32'(e_ig));
    chk("dm_gnt", 32'(dm_gnt), 32'(e_dg));
    chk("stall_if", 32'(stall_if), 32'(!rst && if_req && !e_ig));
    chk("stall_mem", 32'(stall_mem), 32'(!rst && dm_req && !e_dg));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    if (e_en) chk("mem_addr", 32'(mem_addr), e_maddr);
    if (e_we != 0) chk("mem_wdata", mem_wdata, dm_wdata);
    chk("if_rvalid", 32'(if_rvalid), 32'(e_iv));
    chk("if_rdata", if_rdata, e_idata);
    chk("dm_rvalid", 32'(dm_rvalid), 32'(e_dv));
    chk("dm_rdata", dm_rdata, e_ddata);
    chk("dm_err", 32'(dm_err), 32'(e_err));

    if (rst) begin
      denied_run = 0;
      pend       = PEND_NONE;
    end else begin
      if (if_req && !e_ig) denied_run = (denied_run < 15) ? denied_run + 1 : 15;
      else                 denied_run = 0;
      if (e_ig) begin
        pend = PEND_IF;  pend_data = model_mem[iw];
      end else if (e_dg && !dm_we) begin
        pend = oor ? PEND_ERR : PEND_DM;  pend_data = model_mem[dw];
      end else begin
        pend = PEND_NONE;
      end
      if (e_dg && dm_we && !oor)
        for (int b = 0; b < 4; b++)
          if (dm_be[b]) model_mem[dw][8*b +: 8] = dm_wdata[8*b +: 8];
    end
    last_if_gnt = e_ig;
    last_dm_gnt = e_dg;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gen_if_addr();
    if ($urandom_range(0, 3) == 0) return $urandom();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  function automatic logic [31:0] gen_dm_addr();
    int sel = $urandom_range(0, 9);
    if (sel == 0) return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
    if (sel == 1) return 32'($urandom_range(1, 255)) << (AW + 2);
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  initial begin
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h20; dm_wdata = 32'h0;

    // Grants and every output held low during reset, even with requests present.
    repeat (3) begin
      @(negedge clk);
      chk("rst_if_gnt", 32'(if_gnt), 32'h0);
      chk("rst_dm_gnt", 32'(dm_gnt), 32'h0);
      chk("rst_stall_if", 32'(stall_if), 32'h0);
      chk("rst_mem_en", 32'(mem_en), 32'h0);
    end
    tick(); rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;

    // Partial-word write then read back.
    tick(); dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h20; dm_wdata = 32'hAABBCCDD;
    @(negedge clk);
    chk("wr_gnt", 32'(dm_gnt), 32'h1);
    chk("wr_mem_we", 32'(mem_we), 32'h3);
    chk("wr_mem_addr", 32'(mem_addr), 32'h8);
    tick(); dm_we = 1'b0; dm_be = 4'h0;
    @(negedge clk);
    chk("wr_no_rvalid", 32'(dm_rvalid), 32'h0);
    tick(); dm_req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", 32'(dm_rvalid), 32'h1);
    chk("rd_half", dm_rdata, 32'h0000CCDD);

    // Fetch of an instruction placed by a data write.
    tick(); dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h10; dm_wdata = 32'h00500093;
    tick(); dm_req = 1'b0; dm_we = 1'b0; if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("if_gnt_same_cycle", 32'(if_gnt), 32'h1);
    chk("if_mem_addr", 32'(mem_addr), 32'h4);
    tick(); if_req = 1'b0;
    @(negedge clk);
    chk("if_rvalid_next", 32'(if_rvalid), 32'h1);
    chk("if_rdata_next", if_rdata, 32'h00500093);

    // Continuous conflict: DM,DM,DM,IF repeating.
    tick(); if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("starve_if_gnt", 32'(if_gnt), 32'((k % 4) == 3));
      chk("starve_dm_gnt", 32'(dm_gnt), 32'((k % 4) != 3));
      chk("starve_stall_if", 32'(stall_if), 32'((k % 4) != 3));
      tick();
    end
    if_req = 1'b0; dm_req = 1'b0;

    // Out-of-range read: granted, RAM untouched, error in the response cycle.
    tick(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0001_0000;
    @(negedge clk);
    chk("oor_gnt", 32'(dm_gnt), 32'h1);
    chk("oor_mem_en", 32'(mem_en), 32'h0);
    tick(); dm_req = 1'b0;
    @(negedge clk);
    chk("oor_rvalid", 32'(dm_rvalid), 32'h1);
    chk("oor_err", 32'(dm_err), 32'h1);
    chk("oor_rdata", dm_rdata, 32'h0);

    // Reset while a fetch response is pending discards it.
    tick(); if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("pend_if_gnt", 32'(if_gnt), 32'h1);
    tick(); if_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_pend_rvalid0", 32'(if_rvalid), 32'h0);
    tick();
    @(negedge clk);
    chk("rst_pend_rvalid1", 32'(if_rvalid), 32'h0);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid", 32'(if_rvalid), 32'h0);
    chk("post_rst_dm_rvalid", 32'(dm_rvalid), 32'h0);

`ifdef ARB_PERF_CNT_EN
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
    repeat (10) tick();
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    chk("perf_conflict", perf_conflict, 32'd10);
    chk("perf_if_stall", perf_if_stall, 32'd8);
`endif

    // Randomized traffic: requests held until granted, occasional drops and resets.
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst = ($urandom_range(0, 149) == 0);
      if (!if_req || last_if_gnt) begin
        if_req  = ($urandom_range(0, 9) < 7);
        if_addr = gen_if_addr();
      end else if ($urandom_range(0, 19) == 0) begin
        if_req = 1'b0;
      end
      if (!dm_req || last_dm_gnt) begin
        dm_req   = ($urandom_range(0, 9) < 7);
        dm_we    = $urandom_range(0, 1) == 1;
        dm_be    = 4'($urandom_range(0, 15));
        dm_addr  = gen_dm_addr();
        dm_wdata = $urandom();
      end else if ($urandom_range(0, 19) == 0) begin
        dm_req = 1'b0;
      end
    end
    tick(); if_req = 1'b0; dm_req = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
